// File: rtl/instr_pkg.sv
// Shared definitions for the RV32I instruction encoder and immediate generator:
// format enum, opcode constants, the canonical NOP and the buffered word layout.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    // One buffered entry: the encoded word plus its error flag.
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_word_t;

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry valid/ready FIFO. The head register drives the output directly, so
// the output data holds its last value when empty. in_ready is decoded from
// the registered occupancy only, never from out_ready.
module instr_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head;

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples pre-edge values; = here would create order-dependent races between always_ff blocks.
        if (rst) begin
            count <= 2'd0;
        end else if (push && !pop) begin
            count <= count + 2'd1;
        end else if (!push && pop) begin
            count <= count - 2'd1;
        end
    end

    // Head entry: refilled from tail on pop when full, or from the input when it would become the oldest word.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (pop && (count == 2'd2)) begin
            head <= tail;
        end else if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            head <= in_data;
        end
    end

    // Tail entry: written only when a second word arrives behind a held head.
    always_ff @(posedge clk) begin
        // NOTE: tail is storage, not control; it is never read unless count says it holds a word, so it needs no reset.
        if (push && (count == 2'd1) && !pop) begin
            tail <= in_data;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: scatters decoded fields and the immediate into a
// 32-bit instruction word, then buffers {instr, err} in a 2-entry FIFO.
// Optional macro INSTR_ENC_RANGE_CHECK_EN flags immediates that do not fit
// their field; without it, out-of-range bits are silently truncated.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  instr_fmt_t         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    output logic [COUNT_W-1:0] out_count
);

    enc_word_t enc;
    enc_word_t out_word;
    logic      fmt_bad;
    logic      range_err;

    // Format-specific field packing plus error classification.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
        enc.instr = INSTR_NOP;
        fmt_bad   = 1'b0;
        range_err = 1'b0;
        case (in_fmt)
            FMT_R: enc.instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc.instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc.instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc.instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc.instr = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc.instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
            default: fmt_bad = 1'b1;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        // A signed immediate fits when all bits above its sign bit copy the sign.
        case (in_fmt)
            FMT_I, FMT_S: range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            FMT_B:        range_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            FMT_J:        range_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            FMT_U:        range_err = |in_imm[11:0];
            default:      range_err = 1'b0;
        endcase
`else
        range_err = 1'b0;
`endif
        enc.err = fmt_bad || range_err;
    end

    instr_fifo2 #(
        .WIDTH ($bits(enc_word_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_word)
    );

    assign out_instr = out_word.instr;
    assign out_err   = out_word.err;

    // Output handshake counter, wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, backpressure,
// mid-operation reset and randomized traffic against a queue-based model.
module tb_instr_encoder;
    import instr_pkg::*;

    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    instr_fmt_t         in_fmt;
    logic [6:0]         in_opcode;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic [31:0]        in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic               out_err;
    logic [COUNT_W-1:0] out_count;

    instr_encoder #(.COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_instr;
    int unsigned n_out;
    int          checks = 0;
    int          errors = 0;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: instruction word built from field positions with shifts and masks,
    // error from signed integer ranges.
    function automatic exp_t model(input logic [2:0] fmt, input logic [6:0] opc,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
        exp_t        r;
        logic [31:0] base;
        int          s;
        s    = int'(signed'(imm));
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(opc);
        r.err = 1'b0;
        case (fmt)
            3'd0: r.instr = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            3'd1: r.instr = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
            3'd2: r.instr = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base
                            | ((imm & 32'h1F) << 7);
            3'd3: r.instr = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                            | (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8)
                            | (((imm >> 11) & 32'h1) << 7);
            3'd4: r.instr = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(opc);
            3'd5: r.instr = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                            | (32'(rd) << 7) | 32'(opc);
            default: begin
                r.instr = 32'h00000013;
                r.err   = 1'b1;
            end
        endcase
        if (RANGE_ON) begin
            case (fmt)
                3'd1, 3'd2: if (s < -2048 || s > 2047) r.err = 1'b1;
                3'd3: if (s < -4096 || s > 4094 || (s % 2) != 0) r.err = 1'b1;
                3'd5: if (s < -1048576 || s > 1048574 || (s % 2) != 0) r.err = 1'b1;
                3'd4: if ((imm & 32'hFFF) != 32'h0) r.err = 1'b1;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic set_fields(input int fmt, input logic [6:0] opc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_fmt    = instr_fmt_t'(fmt[2:0]);
        in_opcode = opc;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic randomize_fields();
        int          mode;
        int          s;
        logic [31:0] imm;
        mode = int'($urandom_range(0, 3));
        case (mode)
            0: s = int'($urandom_range(0, 8191)) - 4096;
            1: s = (int'($urandom_range(0, 4095)) - 2048) * 2;
            2: s = int'($urandom_range(0, 15)) << 12;
            default: s = int'($urandom);
        endcase
        imm = 32'(s);
        set_fields(int'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), 7'($urandom), imm);
    endtask

    // One clock: drive, sample at the falling edge, update the model, advance.
    task automatic cycle(input logic iv, input logic ordy, output logic accepted);
        logic model_push;
        logic model_pop;
        in_valid  = iv;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("out_count", 32'(out_count), 32'(COUNT_W'(n_out)));
        if (q.size() != 0) begin
            check("out_instr", out_instr, q[0].instr);
            check("out_err", 32'(out_err), 32'(q[0].err));
        end else begin
            check("empty_hold", out_instr, last_instr);
        end
        model_push = iv && (q.size() < 2);
        model_pop  = ordy && (q.size() != 0);
        if (model_pop) begin
            last_instr = q[0].instr;
            void'(q.pop_front());
            n_out++;
        end
        if (model_push) begin
            q.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                              in_funct3, in_funct7, in_imm));
        end
        accepted = model_push;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 6 && q.size() != 0; i++) cycle(1'b0, 1'b1, acc);
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        q.delete();
        n_out      = 0;
        last_instr = 32'h0;
    endtask

    // Accept one bundle into an empty buffer and check the word one cycle later.
    task automatic directed(input string tag, input int fmt, input logic [6:0] opc,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [31:0] imm,
                            input logic [31:0] exp_word, input logic exp_err);
        logic acc;
        drain();
        set_fields(fmt, opc, rd, rs1, rs2, f3, 7'h0, imm);
        cycle(1'b1, 1'b0, acc);
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, out_instr, exp_word);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        drain();
    endtask

    initial begin
        logic acc;
        int   accepts;
        int   guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_fields(0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
        repeat (2) @(posedge clk);
        do_reset();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);

        directed("dir_I", 1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
        check("count_after_I", 32'(out_count), 32'd1);
        directed("dir_S", 2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020A423, 1'b0);
        directed("dir_B", 3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        directed("dir_U", 4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);
        directed("dir_J", 5, OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 32'h0000006F, 1'b0);
        directed("rng_I", 1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h80000093, RANGE_ON);
        directed("rng_B", 3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h00000163, RANGE_ON);
        directed("bad_fmt", 7, OP_REG, 5'd3, 5'd4, 5'd5, 3'd1, 32'hFFFFFFFF, 32'h00000013, 1'b1);

        // Backpressure: three back-to-back bundles with out_ready low.
        accepts = 0;
        randomize_fields();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, acc);
            if (acc) begin
                accepts++;
                randomize_fields();
            end
        end
        check("bp_accepts", 32'(accepts), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        guard = 0;
        while (accepts < 3 && guard < 10) begin
            cycle(1'b1, 1'b1, acc);
            if (acc) accepts++;
            guard++;
        end
        check("bp_third_accepted", 32'(accepts), 32'd3);
        in_valid = 1'b0;
        drain();

        // Reset with two words buffered.
        for (int i = 0; i < 2; i++) begin
            randomize_fields();
            cycle(1'b1, 1'b0, acc);
        end
        check("pre_rst_full", 32'(in_ready), 32'd0);
        do_reset();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_count", 32'(out_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic with varying valid/ready densities.
        randomize_fields();
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 150; i++) begin
                logic iv;
                logic ordy;
                iv   = ($urandom_range(0, 3) <= phase) ? 1'b1 : 1'b0;
                ordy = ($urandom_range(0, 3) >= phase) ? 1'b1 : 1'b0;
                cycle(iv, ordy, acc);
                if (acc) randomize_fields();
            end
        end
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs decoded instruction fields (format, opcode, registers, funct fields, 32-bit immediate) into a 32-bit RV32I instruction word. It is the inverse of the immediate generator: it scatters the immediate into the format-specific bit positions that the generator gathers from. It is used by the boot/test instruction-stream builder that writes instruction memory. It has a valid/ready input, a 2-entry output buffer, and a valid/ready output.

Parameters:
- COUNT_W, 16, width of the accepted-instruction counter out_count.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_fmt  input  3  instruction format code (package enum)
- in_opcode  input  7  opcode field
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field
- in_imm  input  32  immediate, sign-extended byte offset or value
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  encoded instruction
- out_err  output  1  error flag travelling with out_instr
- out_count  output  COUNT_W  number of output handshakes since reset

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - On rst: buffer empty, out_valid=0, out_instr=0, out_err=0, out_count=0, in_ready=1 in the cycle after reset.
  - rst mid-operation discards all buffered words.
- Input handshake:
  - A bundle is accepted when in_valid && in_ready.
  - in_ready = !full. It is a registered buffer state with no combinational path from out_ready.
- Encoding (combinational before the buffer):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Fields a format does not use are ignored.
- Invalid in_fmt (6, 7):
  - Encoded word is 32'h00000013 (addi x0,x0,0).
  - err=1, always, independent of the optional feature.
- Buffer:
  - 2-entry FIFO of {instr, err}.
  - Latency: a bundle accepted in cycle N appears on out_instr with out_valid=1 in cycle N+1 if the buffer was empty.
  - Throughput is 1 per cycle under continuous out_ready.
  - The buffer presents FIFO order.
  - out_instr and out_err hold stable while out_valid && !out_ready.
- Boundary cases:
  - Simultaneous push and pop when full: pop succeeds; the push is blocked because in_ready=0 that cycle.
  - Simultaneous push and pop when 1 entry: occupancy stays 1; the new word follows.
  - Empty: out_valid=0; out_instr holds its last value.
- Counter: out_count increments on each out_valid && out_ready and wraps modulo 2^COUNT_W.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: err=1 when the immediate does not fit its field:
  - I/S: outside [-2048, 2047].
  - B: outside [-4096, 4094] or imm[0]=1.
  - J: outside [-1048576, 1048574] or imm[0]=1.
  - U: imm[11:0] != 0.
  - R: never.
  - The word is still encoded with truncated bits.
- Undefined: err is set only for an invalid in_fmt; out-of-range bits are silently truncated.

Decomposition:
- Shared package instr_pkg:
  - typedef enum logic [2:0] instr_fmt_t: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
  - Opcode constants: OP_LUI=7'b0110111, OP_JAL=7'b1101111, OP_BRANCH=7'b1100011, OP_STORE=7'b0100011, OP_IMM=7'b0010011, OP_REG=7'b0110011.
  - NOP constant 32'h00000013.
  - The immediate generator uses the same enum.
- One sub-module: instr_fifo2, a 2-entry valid/ready FIFO parameterised on data width.
- Encoding and range checking stay in instr_encoder as one always_comb.

Test Plan:
- I, opcode OP_IMM, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093 one cycle after accept, err=0, out_count=1 after handshake.
- S, OP_STORE, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423. B, OP_BRANCH, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
- U, OP_LUI, rd=5, imm=0x12345000 -> 0x123452B7. J, OP_JAL, rd=0, imm=0 -> 0x0000006F.
- out_ready=0 with 3 back-to-back bundles -> in_ready falls after the 2nd accept; third is held; out_instr stable. Raising out_ready drains all 3 in order.
- With INSTR_ENC_RANGE_CHECK_EN: I with imm=2048 -> err=1; B with imm=3 -> err=1. Without the macro both give err=0. in_fmt=7 -> 0x00000013, err=1 in both builds.
- rst asserted with 2 words buffered -> next cycle out_valid=0, out_count=0, in_ready=1.
